// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC types, real-valued constants and elaboration-time angle/scaling helpers
package cordic_pkg;
  typedef enum logic {CORDIC_ROTATE = 1'b0, CORDIC_VECTOR = 1'b1} cordic_mode_e;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} cordic_state_e;
  localparam real CORDIC_PI = 3.14159265358979323846;
  localparam real CORDIC_GAIN = 1.6467602581210654;
  localparam real CORDIC_INV_GAIN = 0.6072529350088813;
  function automatic real cordic_pow2(int n);
    real r = 1.0;
    for (int k = 0; k < n; k++) r = r * 2.0;
    for (int k = 0; k < -n; k++) r = r / 2.0;
    return r;
  endfunction
  function automatic int cordic_scale(real r, int frac);
    return $rtoi(r * cordic_pow2(frac) + 0.5);
  endfunction
  function automatic int cordic_atan(int i, int zw);
    real x = cordic_pow2(-i);
    real t = x;
    real s = 0.0;
    for (int k = 0; k < 60; k++) begin
      s = s + t / (2.0 * k + 1.0);
      t = -t * x * x;
    end
    if (i == 0) s = CORDIC_PI / 4.0;
    return cordic_scale(s / CORDIC_PI, zw - 1);
  endfunction
endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: atan(2^-i) binary-angle table (i_idx: iteration index, o_atan: angle, zero past N-1)
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int N  = 14,
  parameter int ZW = 18,
  parameter int CW = 4
) (
  input  logic [CW-1:0] i_idx,
  output logic [ZW-1:0] o_atan
);
  logic [ZW-1:0] w_tab [2**CW];
  for (genvar i = 0; i < 2**CW; i++) begin : g_tab
    assign w_tab[i] = i < N ? ZW'(cordic_atan(i, ZW)) : '0;
  end
  assign o_atan = w_tab[i_idx];
endmodule

// File: rtl/cordic_engine.sv
// cordic_engine: iterative CORDIC rotate/vector core (in_* request handshake, out_* saturated result handshake)
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int GUARD      = 2,
  parameter int ITERATIONS = WIDTH - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             out_mode
);
  localparam int ZW = WIDTH + GUARD;
  localparam int XW = WIDTH + GUARD + 2;
  localparam int CW = $clog2(ITERATIONS + 1);
  localparam logic signed [ZW-1:0] QPI  = {2'b01, {(ZW-2){1'b0}}};
  localparam logic signed [ZW-1:0] MPI  = {1'b1, {(ZW-1){1'b0}}};
  localparam logic signed [ZW-1:0] ZRND = ZW'((2**GUARD) / 2);
  localparam logic signed [XW-1:0] XRND = XW'((2**GUARD) / 2);
  localparam logic signed [XW-1:0] SMAX = XW'(2**(WIDTH-1) - 1);
  localparam logic signed [XW-1:0] SMIN = -SMAX - 1;
  if (ITERATIONS < 4 || ITERATIONS > WIDTH + GUARD - 1) begin : g_bad_iter
    $error("cordic_engine: ITERATIONS out of range 4..WIDTH+GUARD-1");
  end
  cordic_state_e r_state, w_next;
  cordic_mode_e r_mode;
  logic [CW-1:0] r_cnt;
  logic signed [XW-1:0] r_x, r_y, w_xi, w_yi, w_x0, w_y0, w_xn, w_yn, w_xr, w_yr;
  logic signed [ZW-1:0] r_z, w_zi, w_z0, w_zn, w_atan;
  logic [WIDTH-1:0] r_out_x, r_out_y, r_out_z;
  logic r_out_mode, w_dneg, w_last;
  cordic_atan_rom #(.N(ITERATIONS), .ZW(ZW), .CW(CW)) u_rom (.i_idx(r_cnt), .o_atan(w_atan));
  function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    return v > SMAX ? SMAX[WIDTH-1:0] : v < SMIN ? SMIN[WIDTH-1:0] : v[WIDTH-1:0];
  endfunction
  assign w_xi = XW'($signed(in_x)) <<< GUARD;
  assign w_yi = XW'($signed(in_y)) <<< GUARD;
  assign w_zi = ZW'($signed(in_z)) <<< GUARD;
  // quadrant fold so the remaining angle lies inside the CORDIC convergence range
  always_comb begin
    w_x0 = w_xi;
    w_y0 = w_yi;
    w_z0 = w_zi;
    if (in_mode) begin
      w_x0 = w_xi < 0 ? -w_xi : w_xi;
      w_y0 = w_xi < 0 ? -w_yi : w_yi;
      w_z0 = w_xi < 0 ? MPI : '0;
    end else if (w_zi > QPI) begin
      w_x0 = -w_yi;
      w_y0 = w_xi;
      w_z0 = w_zi - QPI;
    end else if (w_zi < -QPI) begin
      w_x0 = w_yi;
      w_y0 = -w_xi;
      w_z0 = w_zi + QPI;
    end
  end
  // w_dneg: micro-rotation direction d = -1
  assign w_dneg = r_mode == CORDIC_VECTOR ? ~r_y[XW-1] : r_z[ZW-1];
  assign w_xn = w_dneg ? r_x + (r_y >>> r_cnt) : r_x - (r_y >>> r_cnt);
  assign w_yn = w_dneg ? r_y - (r_x >>> r_cnt) : r_y + (r_x >>> r_cnt);
  assign w_zn = w_dneg ? r_z + w_atan : r_z - w_atan;
  assign w_xr = (r_x + XRND) >>> GUARD;
  assign w_yr = (r_y + XRND) >>> GUARD;
  // the extra ITER cycle at count ITERATIONS rounds and saturates into the output registers
  assign w_last = r_cnt == CW'(ITERATIONS);
  always_comb begin
    w_next = r_state;
    in_ready = r_state == S_IDLE;
    out_valid = r_state == S_DONE;
    w_next = r_state == S_IDLE ? (in_valid ? S_ITER : S_IDLE)
           : r_state == S_ITER ? (w_last ? S_DONE : S_ITER)
           : (out_ready ? S_IDLE : S_DONE);
  end
  always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
      r_mode <= CORDIC_ROTATE;
      r_cnt <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
      r_out_z <= '0;
      r_out_mode <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_x <= w_x0;
      r_y <= w_y0;
      r_z <= w_z0;
      r_mode <= cordic_mode_e'(in_mode);
      r_cnt <= '0;
    end else if (r_state == S_ITER) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_out_x <= sat(w_xr);
        r_out_y <= sat(w_yr);
        r_out_z <= WIDTH'((r_z + ZRND) >>> GUARD);
        r_out_mode <= r_mode;
      end else begin
        r_x <= w_xn;
        r_y <= w_yn;
        r_z <= w_zn;
      end
    end
  end
  assign out_x = r_out_x;
  assign out_y = r_out_y;
  assign out_z = r_out_z;
  assign out_mode = r_out_mode;
endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: directed self-checking bench for cordic_engine at WIDTH=16
module tb_cordic_engine;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, in_mode = 1'b0;
  logic out_valid, out_ready = 1'b0, out_mode;
  logic [15:0] in_x = '0, in_y = '0, in_z = '0, out_x, out_y, out_z;
  int n_tests = 0, n_fail = 0, lat;
  cordic_engine #(.WIDTH(16), .GUARD(2), .ITERATIONS(14)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_mode(out_mode)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp, input int tol);
    int d;
    d = int'(shortint'(got - exp));
    n_tests++;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask
  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction
  task automatic send(input logic m, input int x, input int y, input int z);
    int g = 0;
    in_valid = 1'b1;
    in_mode = m;
    in_x = 16'(x);
    in_y = 16'(y);
    in_z = 16'(z);
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask
  task automatic take;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_out_x", sx(out_x), 0, 0);
    check("rst_out_y", sx(out_y), 0, 0);
    check("rst_out_z", sx(out_z), 0, 0);
    check("rst_out_mode", int'(out_mode), 0, 0);
    send(1'b0, 9949, 0, 'h2000);
    wait_out(lat);
    check("rot45_latency", lat, 15, 0);
    check("rot45_x", sx(out_x), 11585, 3);
    check("rot45_y", sx(out_y), 11585, 3);
    check("rot45_z", sx(out_z), 0, 4);
    check("rot45_mode", int'(out_mode), 0, 0);
    take();
    send(1'b1, 3000, 4000, 0);
    wait_out(lat);
    check("vec_latency", lat, 15, 0);
    check("vec_x", sx(out_x), 8234, 3);
    check("vec_y", sx(out_y), 0, 4);
    check("vec_z", sx(out_z), 9672, 3);
    check("vec_mode", int'(out_mode), 1, 0);
    take();
    send(1'b0, 9949, 0, 'h8000);
    wait_out(lat);
    check("rot180_x", sx(out_x), -16384, 3);
    check("rot180_y", sx(out_y), 0, 4);
    take();
    send(1'b1, -3000, 0, 0);
    wait_out(lat);
    check("vecneg_z", sx(out_z), -32768, 2);
    check("vecneg_x", sx(out_x), 4940, 3);
    take();
    send(1'b1, 32767, 32767, 0);
    wait_out(lat);
    check("sat_x", sx(out_x), 32767, 0);
    check("sat_z", sx(out_z), 8192, 3);
    take();
    send(1'b0, 9949, 0, 'h2000);
    wait_out(lat);
    in_valid = 1'b1;
    in_mode = 1'b1;
    in_x = 16'd3000;
    in_y = 16'd4000;
    in_z = '0;
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", int'(out_valid), 1, 0);
      check("bp_in_ready", int'(in_ready), 0, 0);
      check("bp_x", sx(out_x), 11585, 3);
      check("bp_y", sx(out_y), 11585, 3);
      check("bp_z", sx(out_z), 0, 4);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_out_valid", int'(out_valid), 0, 0);
    check("bp_idle_in_ready", int'(in_ready), 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_accepted", int'(in_ready), 0, 0);
    wait_out(lat);
    check("bp_second_latency", lat, 15, 0);
    check("bp_second_x", sx(out_x), 8234, 3);
    check("bp_second_z", sx(out_z), 9672, 3);
    take();
    send(1'b0, 9949, 0, 'h2000);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1, 0);
    check("midrst_out_valid", int'(out_valid), 0, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      seen |= int'(out_valid);
      @(posedge clk); #1;
    end
    check("midrst_no_pulse", seen, 0, 0);
    send(1'b1, 3000, 4000, 0);
    wait_out(lat);
    check("midrst_next_latency", lat, 15, 0);
    check("midrst_next_x", sx(out_x), 8234, 3);
    check("midrst_next_z", sx(out_z), 9672, 3);
    take();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
